// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store.
// Data accesses win by default; a starvation counter bounds how long a fetch waits.
module mem_port_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              d_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACC_I = 2'd1;
  localparam logic [1:0] ST_ACC_D = 2'd2;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [1:0]        state_q, state_d;
  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic              flushed_q, flushed_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_valid_q, if_valid_d;
  logic              d_valid_q, d_valid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic d_elig, i_elig, grant_d, grant_i;

  // A requester whose completion is pulsing this cycle is masked so a held
  // request is not served a second time.
  assign d_elig  = d_req & ~d_valid_q;
  assign i_elig  = if_req & ~if_valid_q & ~if_flush;
  assign grant_d = (state_q == ST_IDLE) & d_elig & (~i_elig | (starve_cnt_q < STARVE_LIM));
  assign grant_i = (state_q == ST_IDLE) & i_elig & ~grant_d;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d      = state_q;
    flushed_d    = flushed_q;
    mem_en_d     = mem_en_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_valid_d   = 1'b0;
    d_valid_d    = 1'b0;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    starve_cnt_d = starve_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_d) begin
          state_d     = ST_ACC_D;
          mem_en_d    = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
        end else if (grant_i) begin
          state_d     = ST_ACC_I;
          mem_en_d    = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
        end
      end
      ST_ACC_I: begin
        if (if_flush) flushed_d = 1'b1;
        if (mem_ready) begin
          state_d   = ST_IDLE;
          mem_en_d  = 1'b0;
          flushed_d = 1'b0;
          // A flush arriving in the completion cycle still discards the fetch.
          if (!(flushed_q || if_flush)) begin
            if_valid_d = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end
      end
      ST_ACC_D: begin
        if (mem_ready) begin
          state_d   = ST_IDLE;
          mem_en_d  = 1'b0;
          d_valid_d = 1'b1;
          if (!mem_we_q) d_rdata_d = mem_rdata;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        mem_en_d  = 1'b0;
        flushed_d = 1'b0;
      end
    endcase

    if (!if_req || grant_i) begin
      starve_cnt_d = '0;
    end else if (grant_d && (starve_cnt_q < STARVE_LIM)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      starve_cnt_q <= '0;
      flushed_q    <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_valid_q   <= 1'b0;
      d_valid_q    <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      flushed_q    <= flushed_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_valid_q   <= if_valid_d;
      d_valid_q    <= d_valid_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_valid  = if_valid_q;
  assign if_rdata  = if_rdata_q;
  assign d_valid   = d_valid_q;
  assign d_rdata   = d_rdata_q;
  assign if_stall  = if_req & ~if_valid_q;
  assign d_stall   = d_req & ~d_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by random traffic,
// all compared cycle by cycle against a transaction-level ownership model.
module tb_mem_port_arbiter;
  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              if_req = 1'b0, if_flush = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid, if_stall;
  logic              d_req = 1'b0, d_we = 1'b0;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [DATA_W-1:0] d_wdata = '0;
  logic [DATA_W-1:0] d_rdata;
  logic              d_valid, d_stall;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              mem_ready = 1'b0;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: who owns the memory, what access is outstanding, and what each stage last received.
  typedef enum {FREE, FETCHING, DATA} owner_e;
  owner_e            m_owner;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  bit                m_discard;
  int                m_starve;
  logic              m_if_valid, m_d_valid;
  logic [DATA_W-1:0] m_if_rdata, m_d_rdata;

  bit                grant_log[$];   // 1 = data grant, 0 = fetch grant
  logic [DATA_W-1:0] mem_arr[int];
  int mem_lat = 0, acc_cycles = 0, en_cycles = 0, dvalid_cnt = 0;
  bit i_busy = 0, d_busy = 0;

  function automatic logic [DATA_W-1:0] mem_read(input logic [ADDR_W-1:0] a);
    if (mem_arr.exists(int'(a))) return mem_arr[int'(a)];
    return {a ^ 16'h5A5A, a};
  endfunction

  function automatic logic [ADDR_W-1:0] rand_addr();
    return 16'($urandom_range(255)) & 16'hFFFC;
  endfunction

  task automatic m_reset();
    m_owner = FREE; m_we = 1'b0; m_addr = '0; m_wdata = '0; m_discard = 0;
    m_starve = 0; m_if_valid = 1'b0; m_d_valid = 1'b0; m_if_rdata = '0; m_d_rdata = '0;
    acc_cycles = 0;
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_mem_en"}, mem_en, 0);
    check({pfx, "_mem_we"}, mem_we, 0);
    check({pfx, "_mem_addr"}, mem_addr, 0);
    check({pfx, "_mem_wdata"}, mem_wdata, 0);
    check({pfx, "_if_valid"}, if_valid, 0);
    check({pfx, "_d_valid"}, d_valid, 0);
    check({pfx, "_if_rdata"}, if_rdata, 0);
    check({pfx, "_d_rdata"}, d_rdata, 0);
    check({pfx, "_if_stall"}, if_stall, if_req);
    check({pfx, "_d_stall"}, d_stall, d_req);
  endtask

  // One clock cycle: called at a falling edge with inputs already set, returns at the next one.
  task automatic step();
    owner_e            n_owner;
    logic              n_we, n_iv, n_dv;
    logic [ADDR_W-1:0] n_addr;
    logic [DATA_W-1:0] n_wdata, n_ir, n_dr;
    bit                n_discard, d_ok, i_ok, gd, gi;
    int                n_starve;

    check("mem_en", mem_en, m_owner != FREE);
    if (m_owner != FREE) begin
      check("mem_we", mem_we, m_we);
      check("mem_addr", mem_addr, m_addr);
      if (m_we) check("mem_wdata", mem_wdata, m_wdata);
    end
    check("if_valid", if_valid, m_if_valid);
    check("d_valid", d_valid, m_d_valid);
    check("if_rdata", if_rdata, m_if_rdata);
    check("d_rdata", d_rdata, m_d_rdata);
    if (mem_en === 1'b1) en_cycles++;
    if (d_valid === 1'b1) dvalid_cnt++;

    if (m_owner != FREE) begin
      acc_cycles++;
      mem_ready = (mem_lat > 0) ? (acc_cycles == mem_lat) : ($urandom_range(2) == 0);
      mem_rdata = mem_ready ? mem_read(m_addr) : $urandom;
    end else begin
      acc_cycles = 0;
      mem_ready  = ($urandom_range(7) == 0);
      mem_rdata  = $urandom;
    end
    #1;
    check("if_stall", if_stall, if_req & ~m_if_valid);
    check("d_stall", d_stall, d_req & ~m_d_valid);

    n_owner = m_owner; n_we = m_we; n_addr = m_addr; n_wdata = m_wdata;
    n_discard = m_discard; n_starve = m_starve;
    n_iv = 1'b0; n_dv = 1'b0; n_ir = m_if_rdata; n_dr = m_d_rdata;
    gd = 0; gi = 0;
    if (m_owner == FREE) begin
      d_ok = d_req && !m_d_valid;
      i_ok = if_req && !m_if_valid && !if_flush;
      if (d_ok && (!i_ok || m_starve < STARVE_MAX)) gd = 1;
      else if (i_ok) gi = 1;
      if (gd) begin n_owner = DATA; n_we = d_we; n_addr = d_addr; n_wdata = d_wdata; end
      if (gi) begin n_owner = FETCHING; n_we = 1'b0; n_addr = if_addr; n_wdata = '0; end
    end else begin
      if (m_owner == FETCHING && if_flush) n_discard = 1;
      if (mem_ready) begin
        n_owner = FREE; n_discard = 0;
        if (m_owner == DATA) begin
          n_dv = 1'b1;
          if (m_we) mem_arr[int'(m_addr)] = m_wdata;
          else n_dr = mem_rdata;
        end else if (!(m_discard || if_flush)) begin
          n_iv = 1'b1; n_ir = mem_rdata;
        end
      end
    end
    if (!if_req || gi) n_starve = 0;
    else if (gd && m_starve < STARVE_MAX) n_starve = m_starve + 1;

    @(posedge clk);
    m_owner = n_owner; m_we = n_we; m_addr = n_addr; m_wdata = n_wdata;
    m_discard = n_discard; m_starve = n_starve;
    m_if_valid = n_iv; m_d_valid = n_dv; m_if_rdata = n_ir; m_d_rdata = n_dr;
    if (gd) grant_log.push_back(1'b1);
    if (gi) grant_log.push_back(1'b0);
    @(negedge clk);
  endtask

  // Run until every raised request has completed, dropping each after its valid pulse.
  task automatic run_txn(input string tag, input int max_cycles);
    bit dv, iv;
    for (int c = 0; c < max_cycles && (if_req || d_req); c++) begin
      dv = m_d_valid; iv = m_if_valid;
      step();
      if (dv) d_req = 1'b0;
      if (iv) if_req = 1'b0;
    end
    check({tag, "_timeout"}, if_req | d_req, 0);
  endtask

  task automatic drive_agents(input bit allow_new);
    if (i_busy) begin
      if (m_if_valid) i_busy = 0;
      else if (if_flush) begin if_flush = 1'b0; if_addr = rand_addr(); end
      else if ($urandom_range(11) == 0) if_flush = 1'b1;
    end else begin
      if_flush = 1'b0;
      if (allow_new && $urandom_range(3) != 0) begin
        i_busy = 1; if_req = 1'b1; if_addr = rand_addr();
      end else if_req = 1'b0;
    end
    if (d_busy) begin
      if (m_d_valid) d_busy = 0;
    end else if (allow_new && $urandom_range(2) == 0) begin
      d_busy = 1; d_req = 1'b1; d_we = 1'($urandom_range(1));
      d_addr = rand_addr(); d_wdata = $urandom;
    end else d_req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    int base, n_d, en0, dv0, ok;
    bit found_i, dv;
    logic [DATA_W-1:0] prev;

    m_reset();
    mem_arr[32'h0010] = 32'h00A00093;
    mem_arr[32'h0100] = 32'hDEADBEEF;
    mem_arr[32'h0040] = 32'h12345678;
    #1 rst = 1'b0;
    #1 check_zero("reset");
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    step();

    // Single fetch with a two-cycle memory.
    mem_lat = 2; en0 = en_cycles;
    if_req = 1'b1; if_addr = 16'h0010;
    step(); step(); step();
    check("fetch_en_cycles", en_cycles - en0, 2);
    check("fetch_valid", if_valid, 1);
    check("fetch_rdata", if_rdata, 32'h00A00093);
    check("fetch_stall_done", if_stall, 0);
    step();
    if_req = 1'b0;
    step();

    // Conflict: data first, then fetch, each exactly once.
    mem_lat = 1; base = grant_log.size();
    if_req = 1'b1; if_addr = 16'h0020;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0100;
    run_txn("conflict", 30);
    check("conflict_grants", grant_log.size() - base, 2);
    check("conflict_first_d", grant_log[base], 1);
    check("conflict_then_i", grant_log[base+1], 0);
    check("conflict_load", d_rdata, 32'hDEADBEEF);

    // Starvation: fetch held off during each data completion, so only the counter frees it.
    base = grant_log.size(); found_i = 0;
    if_req = 1'b1; if_addr = 16'h0030;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0080;
    for (int c = 0; c < 60 && !found_i; c++) begin
      dv = m_d_valid;
      if_flush = dv;
      step();
      if (dv) d_addr = d_addr + 16'd4;
      for (int i = base; i < grant_log.size(); i++) if (!grant_log[i]) found_i = 1;
    end
    if_flush = 1'b0;
    check("starve_i_granted", found_i, 1);
    n_d = 0;
    for (int i = base; i < grant_log.size() && grant_log[i]; i++) n_d++;
    check("starve_d_grants", n_d, STARVE_MAX);
    run_txn("starve_drain", 40);
    check("starve_log_len", grant_log.size() - base, STARVE_MAX + 2);
    check("starve_after_i_d", grant_log[base+STARVE_MAX+1], 1);

    // Flush during an instruction access.
    mem_lat = 3; prev = m_if_rdata;
    if_req = 1'b1; if_addr = 16'h0040;
    step(); step();
    if_flush = 1'b1;
    step();
    if_flush = 1'b0; if_req = 1'b0;
    step();
    check("flush_no_valid", if_valid, 0);
    check("flush_rdata_kept", if_rdata, prev);
    check("flush_back_idle", mem_en, 0);
    step();
    check("flush_no_late_valid", if_valid, 0);

    // Store, then reset in the middle of a fetch.
    mem_lat = 2; prev = m_d_rdata; dv0 = dvalid_cnt;
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0200; d_wdata = 32'hCAFEF00D;
    step();
    check("store_mem_en", mem_en, 1);
    check("store_mem_we", mem_we, 1);
    check("store_mem_addr", mem_addr, 16'h0200);
    check("store_mem_wdata", mem_wdata, 32'hCAFEF00D);
    run_txn("store", 20);
    check("store_d_valid_pulses", dvalid_cnt - dv0, 1);
    check("store_d_rdata_kept", d_rdata, prev);

    mem_lat = 4;
    if_req = 1'b1; if_addr = 16'h0010;
    step(); step();
    check("pre_reset_busy", mem_en, 1);
    #2 rst = 1'b0;
    mem_ready = 1'b0;
    #1 check_zero("async_reset");
    m_reset();
    if_req = 1'b0; if_flush = 1'b0; d_req = 1'b0;
    @(posedge clk); @(negedge clk);
    check_zero("held_reset");
    rst = 1'b1;
    mem_lat = 1; base = grant_log.size();
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0200;
    run_txn("post_reset", 20);
    check("post_reset_grant", grant_log[base], 1);
    check("post_reset_load", d_rdata, 32'hCAFEF00D);

    // Random traffic with random memory latency and spurious mem_ready while idle.
    mem_lat = 0;
    for (int c = 0; c < 2000; c++) begin
      drive_agents(1'b1);
      step();
    end
    ok = 0;
    for (int c = 0; c < 300 && !ok; c++) begin
      drive_agents(1'b0);
      step();
      if (!i_busy && !d_busy && !if_req && !d_req && m_owner == FREE) ok = 1;
    end
    check("random_drain", ok, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
